surf_event_merger: RTL and testbench

Downstream of the per-SURF splice stages. Collects one complete event from each enabled SURF event FIFO in fixed order (SURF0 first, then SURF1, and so on) and emits them as a single framed TURFIO byte stream. The stream starts with a 2-byte event-number header. Also watches each SURF for stalls, so a hung SURF can be found from TURF firmware.

---
 rtl/surf_merge_pkg.sv | 42 ++++
 rtl/surf_event_merger_if.sv | 33 +++
 rtl/surf_event_merger.sv | 142 ++++++++++++++
 tb/tb_surf_event_merger.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/surf_merge_pkg.sv
// ============================================================================
// Package  : surf_merge_pkg
// Brief    : Shared types and the enabled-SURF scan helper for the event merger.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package surf_merge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR0 = 2'd1,
        HDR1 = 2'd2,
        DATA = 2'd3
    } state_t;

    localparam int HDR_BYTES = 2;
    localparam int MAX_SURF  = 32;
    localparam int IDX_W     = 5;

    typedef struct packed {
        logic             none_left;
        logic [IDX_W-1:0] idx;
    } next_t;

    // Lowest set index strictly above cur; cur = -1 yields the first set bit.
    function automatic next_t next_enabled(input logic [MAX_SURF-1:0] mask, input int cur);
        next_t r;
        r.none_left = 1'b1;
        r.idx       = '0;
        for (int i = MAX_SURF - 1; i >= 0; i--) begin
            if (mask[i] && (i > cur)) begin
                r.none_left = 1'b0;
                r.idx       = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/surf_event_merger_if.sv
// ============================================================================
// Interface : surf_event_merger_if
// Brief     : Per-SURF input streams and merged output stream of the merger.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface surf_event_merger_if #(
    parameter int NSURF = 7
);
    logic [8*NSURF-1:0] s_dout_tdata;
    logic [NSURF-1:0]   s_dout_tvalid;
    logic [NSURF-1:0]   s_dout_tlast;
    logic [NSURF-1:0]   s_dout_tready;
    logic [7:0]         m_ev_tdata;
    logic               m_ev_tvalid;
    logic               m_ev_tready;
    logic               m_ev_tlast;

    // master: the environment sourcing SURF bytes and sinking the merged stream
    modport master (
        output s_dout_tdata, s_dout_tvalid, s_dout_tlast, m_ev_tready,
        input  s_dout_tready, m_ev_tdata, m_ev_tvalid, m_ev_tlast
    );

    // slave: the merger itself
    modport slave (
        input  s_dout_tdata, s_dout_tvalid, s_dout_tlast, m_ev_tready,
        output s_dout_tready, m_ev_tdata, m_ev_tvalid, m_ev_tlast
    );
endinterface

`default_nettype wire

// File: rtl/surf_event_merger.sv
// ============================================================================
// Module   : surf_event_merger
// Brief    : Merges one event from each enabled SURF into a framed byte stream
//            with an event-number header, and flags stalled SURFs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module surf_event_merger #(
    parameter int NSURF       = 7,
    parameter int TIMEOUT     = 65535,
    parameter int EVCNT_WIDTH = 16
) (
    input  wire logic                   aclk,
    input  wire logic                   aresetn,
    input  wire logic [NSURF-1:0]       surf_enable_i,
    input  wire logic                   err_clr_i,
    output logic      [NSURF-1:0]       err_o,
    output logic      [EVCNT_WIDTH-1:0] evcount_o,
    surf_event_merger_if.slave          bus
);
    import surf_merge_pkg::*;

    localparam int               c_SEL_W      = (NSURF > 1) ? $clog2(NSURF) : 1;
    localparam int               c_CNT_W      = $clog2(TIMEOUT + 1);
    localparam int               c_HDR_W      = 8 * HDR_BYTES;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT    = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_M1 = c_CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] c_NSURF      = IDX_W'(NSURF);

    state_t                   r_state, w_state_nxt;
    logic [c_SEL_W-1:0]       r_sel, w_sel_nxt;
    logic [NSURF-1:0]         r_enable;
    logic [EVCNT_WIDTH-1:0]   r_evcount;
    logic [c_CNT_W-1:0]       r_stall_cnt;
    logic [NSURF-1:0]         r_err;
    logic [NSURF-1:0]         w_err_nxt;
    logic [7:0]               w_bytes [NSURF];
    logic [c_HDR_W-1:0]       w_hdr;
    next_t                    w_first, w_next;
    logic                     w_first_ok, w_next_ok;
    logic                     w_cur_valid, w_cur_last, w_in_hs, w_stall_hit;
    logic                     w_ld_en, w_ev_inc;

    generate
        for (genvar g = 0; g < NSURF; g++) begin : g_unpack
            assign w_bytes[g] = bus.s_dout_tdata[8*g +: 8];
        end
        if (EVCNT_WIDTH >= c_HDR_W) begin : g_hdr_full
            assign w_hdr = r_evcount[c_HDR_W-1:0];
        end else begin : g_hdr_pad
            assign w_hdr = {{(c_HDR_W - EVCNT_WIDTH){1'b0}}, r_evcount};
        end
    endgenerate

    assign w_first     = next_enabled(MAX_SURF'(surf_enable_i), -1);
    assign w_next      = next_enabled(MAX_SURF'(r_enable), int'(r_sel));
    assign w_first_ok  = !w_first.none_left && (w_first.idx < c_NSURF);
    assign w_next_ok   = !w_next.none_left && (w_next.idx < c_NSURF);
    assign w_cur_valid = bus.s_dout_tvalid[r_sel];
    assign w_cur_last  = bus.s_dout_tlast[r_sel];
    assign w_in_hs     = (r_state == DATA) && w_cur_valid && bus.m_ev_tready;
    assign w_stall_hit = (r_state == DATA) && !w_cur_valid && (r_stall_cnt == c_TIMEOUT_M1);

    always_comb begin
        w_state_nxt       = r_state;
        w_sel_nxt         = r_sel;
        w_ld_en           = 1'b0;
        w_ev_inc          = 1'b0;
        bus.m_ev_tvalid   = 1'b0;
        bus.m_ev_tdata    = 8'h00;
        bus.m_ev_tlast    = 1'b0;
        bus.s_dout_tready = '0;
        case (r_state)
            IDLE: begin
                if (w_first_ok && bus.s_dout_tvalid[w_first.idx[c_SEL_W-1:0]]) begin
                    w_state_nxt = HDR0;
                    w_sel_nxt   = w_first.idx[c_SEL_W-1:0];
                    w_ld_en     = 1'b1;
                end
            end
            HDR0: begin
                bus.m_ev_tvalid = 1'b1;
                bus.m_ev_tdata  = w_hdr[c_HDR_W-1 -: 8];
                if (bus.m_ev_tready) w_state_nxt = HDR1;
            end
            HDR1: begin
                bus.m_ev_tvalid = 1'b1;
                bus.m_ev_tdata  = w_hdr[7:0];
                if (bus.m_ev_tready) w_state_nxt = DATA;
            end
            DATA: begin
                bus.m_ev_tvalid          = w_cur_valid;
                bus.m_ev_tdata           = w_bytes[r_sel];
                bus.m_ev_tlast           = w_cur_last && !w_next_ok;
                bus.s_dout_tready[r_sel] = bus.m_ev_tready;
                // Intermediate SURF tlast only advances sel; it is not forwarded.
                if (w_in_hs && w_cur_last) begin
                    if (w_next_ok) begin
                        w_sel_nxt = w_next.idx[c_SEL_W-1:0];
                    end else begin
                        w_state_nxt = IDLE;
                        w_ev_inc    = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A new stall flag takes priority over a coincident clear.
    assign w_err_nxt = (err_clr_i ? '0 : r_err) |
                       (w_stall_hit ? (NSURF'(1) << r_sel) : '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_enable    <= '0;
            r_evcount   <= '0;
            r_stall_cnt <= '0;
            r_err       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_err   <= w_err_nxt;
            if (w_ld_en)  r_enable  <= surf_enable_i;
            if (w_ev_inc) r_evcount <= r_evcount + 1'b1;
            if ((r_state != DATA) || w_in_hs || (w_sel_nxt != r_sel)) begin
                r_stall_cnt <= '0;
            end else if (!w_cur_valid && (r_stall_cnt != c_TIMEOUT)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign err_o     = r_err;
    assign evcount_o = r_evcount;

endmodule

`default_nettype wire

// File: tb/tb_surf_event_merger.sv
// ============================================================================
// Module   : tb_surf_event_merger
// Brief    : Randomized self-checking bench for surf_event_merger.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_surf_event_merger;

    localparam int NSURF   = 7;
    localparam int TIMEOUT = 16;

    logic             aclk          = 1'b0;
    logic             aresetn       = 1'b0;
    logic [NSURF-1:0] surf_enable_i = '0;
    logic             err_clr_i     = 1'b0;
    logic [NSURF-1:0] err_o;
    logic [15:0]      evcount_o;

    surf_event_merger_if #(.NSURF(NSURF)) bus ();

    surf_event_merger #(
        .NSURF      (NSURF),
        .TIMEOUT    (TIMEOUT),
        .EVCNT_WIDTH(16)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .surf_enable_i(surf_enable_i),
        .err_clr_i    (err_clr_i),
        .err_o        (err_o),
        .evcount_o    (evcount_o),
        .bus          (bus)
    );

    always #5 aclk = ~aclk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_evcount = 16'h0000;
    logic [7:0]  sq [NSURF][$];

    task automatic idle_inputs();
        bus.s_dout_tvalid = '0;
        bus.s_dout_tdata  = '0;
        bus.s_dout_tlast  = '0;
        bus.m_ev_tready   = 1'b0;
    endtask

    // Reference: the expected merged stream is the header followed by every
    // enabled SURF's bytes in index order, tlast only on the very last byte.
    task automatic run_event(input logic [NSURF-1:0] en, input int nmin, input int nmax,
                             input int rprob, input int vprob, input int hold_surf,
                             input int hold_len, input int abort_at,
                             output bit done, output int nout);
        logic [8:0]       exp [$];
        bit               vheld [NSURF];
        int               hold_cnt;
        int               stall_no;
        int               first_ne;
        int               n;
        bit               out_hs;
        logic [NSURF-1:0] in_hs;
        logic [NSURF-1:0] rdy_ok;
        logic [NSURF-1:0] err_exp;
        exp.delete();
        exp.push_back({1'b0, m_evcount[15:8]});
        exp.push_back({1'b0, m_evcount[7:0]});
        for (int s = 0; s < NSURF; s++) begin
            sq[s].delete();
            vheld[s] = 1'b0;
            if (en[s]) begin
                n = $urandom_range(nmax, nmin);
                for (int k = 0; k < n; k++) begin
                    sq[s].push_back(8'($urandom_range(255)));
                    exp.push_back({1'b0, sq[s][k]});
                end
            end
        end
        exp[exp.size()-1][8] = 1'b1;
        surf_enable_i = en;
        nout     = 0;
        hold_cnt = 0;
        done     = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (abort_at > 0 && nout == abort_at) return;
            first_ne = -1;
            for (int s = NSURF - 1; s >= 0; s--) if (sq[s].size() > 0) first_ne = s;
            stall_no = 0;
            if (hold_surf >= 0 && hold_cnt < hold_len && nout >= 2 && first_ne == hold_surf) begin
                hold_cnt++;
                stall_no = hold_cnt;
            end
            for (int s = 0; s < NSURF; s++) begin
                if (sq[s].size() == 0) begin
                    vheld[s] = 1'b0;
                    bus.s_dout_tvalid[s]     = 1'b0;
                    bus.s_dout_tdata[8*s +: 8] = 8'h00;
                    bus.s_dout_tlast[s]      = 1'b0;
                end else begin
                    if (s == hold_surf && hold_cnt < hold_len) vheld[s] = 1'b0;
                    else vheld[s] = vheld[s] || ($urandom_range(99) < vprob);
                    bus.s_dout_tvalid[s]     = vheld[s];
                    bus.s_dout_tdata[8*s +: 8] = sq[s][0];
                    bus.s_dout_tlast[s]      = (sq[s].size() == 1);
                end
            end
            bus.m_ev_tready = ($urandom_range(99) < rprob);
            #1;
            rdy_ok = bus.m_ev_tready ? en : '0;
            checks++;
            if ((bus.s_dout_tready & ~rdy_ok) !== '0) begin
                errors++;
                $display("FAIL rdy_gate got %b allowed %b", bus.s_dout_tready, rdy_ok);
            end
            if (stall_no > 0) begin
                err_exp = (stall_no - 1 >= TIMEOUT) ? (NSURF'(1) << hold_surf) : '0;
                checks++;
                if (err_o !== err_exp) begin
                    errors++;
                    $display("FAIL stall_err cycle %0d got %b want %b", stall_no, err_o, err_exp);
                end
            end
            if (bus.m_ev_tvalid === 1'b1) begin
                checks++;
                if (exp.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat got %h want none", bus.m_ev_tdata);
                end else if ({bus.m_ev_tlast, bus.m_ev_tdata} !== exp[0]) begin
                    errors++;
                    $display("FAIL beat%0d got %h want %h", nout,
                             {bus.m_ev_tlast, bus.m_ev_tdata}, exp[0]);
                end
            end
            out_hs = bus.m_ev_tvalid && bus.m_ev_tready;
            in_hs  = bus.s_dout_tvalid & bus.s_dout_tready;
            @(posedge aclk);
            #1;
            if (out_hs && exp.size() > 0) begin
                void'(exp.pop_front());
                nout++;
            end
            for (int s = 0; s < NSURF; s++) begin
                if (in_hs[s] && sq[s].size() > 0) begin
                    void'(sq[s].pop_front());
                    vheld[s] = 1'b0;
                end
            end
            if (exp.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        idle_inputs();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL event_timeout got %0d beats want %0d more", nout, exp.size());
        end else begin
            m_evcount = m_evcount + 16'd1;
            checks++;
            if (evcount_o !== m_evcount) begin
                errors++;
                $display("FAIL evcount got %h want %h", evcount_o, m_evcount);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        aresetn = 1'b0;
        #1;
        checks++;
        if ({bus.m_ev_tvalid, bus.m_ev_tlast, bus.s_dout_tready, err_o, evcount_o} !== '0) begin
            errors++;
            $display("FAIL reset_state got v%b l%b r%b e%b c%h want all zero", bus.m_ev_tvalid,
                     bus.m_ev_tlast, bus.s_dout_tready, err_o, evcount_o);
        end
        @(posedge aclk);
        #1;
        aresetn   = 1'b1;
        m_evcount = 16'h0000;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_all_surfs();
        bit done;
        int nout;
        run_event(7'h7F, 3, 3, 100, 100, -1, 0, 0, done, nout);
        checks++;
        if (nout != 23) begin
            errors++;
            $display("FAIL all_surfs_beats got %0d want 23", nout);
        end
    endtask

    task automatic test_sparse();
        bit done;
        int nout;
        for (int i = 0; i < 3; i++) run_event(7'b0100101, 1, 4, 100, 80, -1, 0, 0, done, nout);
    endtask

    task automatic test_backpressure();
        bit done;
        int nout;
        for (int i = 0; i < 6; i++) begin
            int a = $urandom_range(NSURF - 1);
            int b = $urandom_range(NSURF - 1);
            logic [NSURF-1:0] en = (NSURF'(1) << a) | (NSURF'(1) << b);
            run_event(en, 2, 6, 50, 70, -1, 0, 0, done, nout);
        end
    endtask

    task automatic test_stall();
        bit done;
        int nout;
        err_clr_i = 1'b1;
        @(posedge aclk);
        #1;
        err_clr_i = 1'b0;
        run_event(7'b0000011, 3, 3, 100, 100, 1, 20, 0, done, nout);
        checks++;
        if (err_o !== 7'b0000010) begin
            errors++;
            $display("FAIL stall_sticky got %b want 0000010", err_o);
        end
        err_clr_i = 1'b1;
        @(posedge aclk);
        #1;
        err_clr_i = 1'b0;
        checks++;
        if (err_o !== 7'b0000000) begin
            errors++;
            $display("FAIL err_clear got %b want 0000000", err_o);
        end
    endtask

    task automatic test_wrap();
        bit done;
        int nout;
        force dut.r_evcount = 16'hFFFF;
        @(posedge aclk);
        #1;
        release dut.r_evcount;
        m_evcount = 16'hFFFF;
        run_event(7'b0001001, 1, 3, 100, 100, -1, 0, 0, done, nout);
        run_event(7'b1000000, 1, 3, 100, 100, -1, 0, 0, done, nout);
    endtask

    task automatic test_reset_mid_event();
        bit done;
        int nout;
        run_event(7'h7F, 3, 3, 100, 100, -1, 0, 12, done, nout);
        bus.s_dout_tvalid[3] = 1'b1;
        bus.m_ev_tready      = 1'b0;
        #1;
        checks++;
        if (bus.m_ev_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got %b want 1", bus.m_ev_tvalid);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if ({bus.m_ev_tvalid, bus.s_dout_tready, evcount_o} !== '0) begin
            errors++;
            $display("FAIL async_reset got v%b r%b c%h want all zero", bus.m_ev_tvalid,
                     bus.s_dout_tready, evcount_o);
        end
        idle_inputs();
        @(posedge aclk);
        #1;
        aresetn   = 1'b1;
        m_evcount = 16'h0000;
        @(posedge aclk);
        #1;
        run_event(7'b0010110, 1, 3, 100, 100, -1, 0, 0, done, nout);
    endtask

    initial begin
        test_reset();
        test_all_surfs();
        test_sparse();
        test_backpressure();
        test_stall();
        test_wrap();
        test_reset_mid_event();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
